// File: rtl/parallel_axis_frame_capture_pkg.sv
// -----------------------------------------------------------------------------
// parallel_axis_frame_capture_pkg
//   Shared types for the parallel AXIS frame-capture block.
//   - cx_t                  : complex sample, 16-bit signed re/im
//   - frame_capture_state_t : capture controller state, visible on the top port
//   - clog2_min1()          : address width helper that never returns 0
// -----------------------------------------------------------------------------
package parallel_axis_frame_capture_pkg;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cx_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } frame_capture_state_t;

  // A one-entry structure still needs a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parallel_axis_frame_capture_if.sv
// -----------------------------------------------------------------------------
// parallel_axis_frame_capture_if
//   AXI-Stream bundle carrying SAMP_PER_CLK parallel samples per beat.
//   Signals: tdata (SAMP_PER_CLK x dtype), tuser, tlast, tvalid, tready.
//   Modports: master drives the stream, slave consumes it and drives tready.
// -----------------------------------------------------------------------------
interface parallel_axis_frame_capture_if #(
  parameter type dtype        = parallel_axis_frame_capture_pkg::cx_t,
  parameter int  SAMP_PER_CLK = 2,
  parameter int  TUSER        = 16
);
  dtype [SAMP_PER_CLK-1:0] tdata;
  logic [TUSER-1:0]        tuser;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/parallel_axis_frame_capture_sdp_ram.sv
// -----------------------------------------------------------------------------
// parallel_axis_frame_capture_sdp_ram
//   Simple dual-port RAM: one write port, one registered read port.
//   Read-first: a read and a write to the same address in one cycle return
//   the contents from before the write. Read latency is one cycle; rdata
//   holds its value on cycles without a read.
//   Ports: clk, rst (sync, active-high, clears rdata only),
//          we/waddr/wdata (write), re/raddr (read), rdata (registered output).
// -----------------------------------------------------------------------------
module parallel_axis_frame_capture_sdp_ram #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = parallel_axis_frame_capture_pkg::clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // NOTE: the storage array is deliberately left without a reset so it maps
  // onto block RAM; only the output register is cleared.
  // NOTE: non-blocking writes let the read below see the pre-write contents,
  // which is what gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/parallel_axis_frame_capture.sv
// -----------------------------------------------------------------------------
// parallel_axis_frame_capture
//   Captures whole, frame-aligned AXIS frames (FRAME_BEATS beats each) into an
//   on-chip buffer of FRAMES frames. One-shot mode stops when the buffer is
//   full; ring mode wraps and keeps going until stop, ending on a frame
//   boundary. Misplaced or missing tlast sets a sticky frame_err; the beat
//   counter alone defines frame boundaries.
//   Ports: clk, rst (sync, active-high); s_axis (slave stream, tready tied 1);
//          arm/ring/stop control; rd_en/rd_addr -> rd_data/rd_valid (1-cycle);
//          status: state, frames_captured, oldest_frame, full, wrapped,
//          frame_err.
// -----------------------------------------------------------------------------
module parallel_axis_frame_capture
  import parallel_axis_frame_capture_pkg::*;
#(
  parameter  int  SAMP_PER_CLK = 2,
  parameter  int  FFT_LEN      = 64,
  parameter  int  FRAMES       = 4,
  parameter  int  TUSER        = 16,
  parameter  type dtype        = cx_t,
  localparam int  FRAME_BEATS  = FFT_LEN / SAMP_PER_CLK,
  localparam int  DEPTH        = FRAMES * FRAME_BEATS,
  localparam int  AW           = clog2_min1(DEPTH),
  localparam int  OW           = clog2_min1(FRAMES),
  localparam int  W            = SAMP_PER_CLK * $bits(dtype) + TUSER
) (
  input  logic                                clk,
  input  logic                                rst,
  parallel_axis_frame_capture_if.slave        s_axis,
  input  logic                                arm,
  input  logic                                ring,
  input  logic                                stop,
  input  logic                                rd_en,
  input  logic [AW-1:0]                       rd_addr,
  output logic [W-1:0]                        rd_data,
  output logic                                rd_valid,
  output frame_capture_state_t                state,
  output logic [31:0]                         frames_captured,
  output logic [OW-1:0]                       oldest_frame,
  output logic                                full,
  output logic                                wrapped,
  output logic                                frame_err
);

  localparam int            BW         = clog2_min1(FRAME_BEATS);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(FRAME_BEATS - 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [OW-1:0] LAST_FRAME = OW'(FRAMES - 1);

  frame_capture_state_t state_q, state_d;
  logic          ring_q, ring_d;
  logic          stop_pend_q, stop_pend_d;
  logic          sof_q, sof_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [OW-1:0] widx_q, widx_d;      // buffer frame slot currently being written
  logic [31:0]   frames_q, frames_d;
  logic [OW-1:0] oldest_q, oldest_d;
  logic          full_q, full_d;
  logic          wrapped_q, wrapped_d;
  logic          frame_err_q, frame_err_d;
  logic          rd_valid_q, rd_valid_d;
  logic          cap_beat, frame_end, stop_now;

  assign s_axis.tready = 1'b1;

  always_comb begin
    state_d     = state_q;
    ring_d      = ring_q;
    stop_pend_d = stop_pend_q;
    wr_addr_d   = wr_addr_q;
    beat_d      = beat_q;
    widx_d      = widx_q;
    frames_d    = frames_q;
    oldest_d    = oldest_q;
    full_d      = full_q;
    wrapped_d   = wrapped_q;
    frame_err_d = frame_err_q;
    rd_valid_d  = rd_en;
    cap_beat    = 1'b0;
    frame_end   = 1'b0;
    stop_now    = 1'b0;

    // Start-of-frame tracking runs in every state so WAIT_SOF can align.
    sof_d = sof_q;
    if (s_axis.tvalid) sof_d = s_axis.tlast;

    unique case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d     = WAIT_SOF;
          ring_d      = ring;
          stop_pend_d = 1'b0;
          wr_addr_d   = '0;
          beat_d      = '0;
          widx_d      = '0;
          frames_d    = '0;
          oldest_d    = '0;
          full_d      = 1'b0;
          wrapped_d   = 1'b0;
          frame_err_d = 1'b0;
        end
      end
      WAIT_SOF: cap_beat = s_axis.tvalid && sof_q;
      CAPTURE: begin
        cap_beat = s_axis.tvalid;
        stop_now = stop && ring_q;
      end
      default: ;
    endcase

    if (stop_now) stop_pend_d = 1'b1;

    if (cap_beat) begin
      state_d   = CAPTURE;
      frame_end = (beat_q == LAST_BEAT);
      if (s_axis.tlast != frame_end) frame_err_d = 1'b1;

      if (frame_end) begin
        beat_d   = '0;
        frames_d = frames_q + 32'd1;
        widx_d   = (widx_q == LAST_FRAME) ? '0 : widx_q + 1'b1;
        if (wr_addr_q == LAST_ADDR) begin
          wr_addr_d = '0;
          if (ring_q) begin
            wrapped_d = 1'b1;
          end else begin
            state_d = DONE;
            full_d  = 1'b1;
          end
        end else begin
          wr_addr_d = wr_addr_q + 1'b1;
        end
        // Once the ring has wrapped, the next slot to be overwritten holds
        // the oldest complete frame.
        if (ring_q && (wrapped_q || wr_addr_q == LAST_ADDR)) oldest_d = widx_d;
        // A stop seen on this very beat counts as well as an earlier one.
        if (ring_q && (stop_pend_q || stop_now)) begin
          state_d = DONE;
          full_d  = 1'b1;
        end
      end else begin
        beat_d    = beat_q + 1'b1;
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ring_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      sof_q       <= 1'b1;
      wr_addr_q   <= '0;
      beat_q      <= '0;
      widx_q      <= '0;
      frames_q    <= '0;
      oldest_q    <= '0;
      full_q      <= 1'b0;
      wrapped_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ring_q      <= ring_d;
      stop_pend_q <= stop_pend_d;
      sof_q       <= sof_d;
      wr_addr_q   <= wr_addr_d;
      beat_q      <= beat_d;
      widx_q      <= widx_d;
      frames_q    <= frames_d;
      oldest_q    <= oldest_d;
      full_q      <= full_d;
      wrapped_q   <= wrapped_d;
      frame_err_q <= frame_err_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  parallel_axis_frame_capture_sdp_ram #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (cap_beat),
    .waddr (wr_addr_q),
    .wdata ({s_axis.tuser, s_axis.tdata}),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign rd_valid        = rd_valid_q;
  assign state           = state_q;
  assign frames_captured = frames_q;
  assign oldest_frame    = oldest_q;
  assign full            = full_q;
  assign wrapped         = wrapped_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_parallel_axis_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_parallel_axis_frame_capture
//   Directed bench for parallel_axis_frame_capture (SPC=2, FFT_LEN=64,
//   FRAMES=4). A stream generator emits a ramp whose tuser equals the global
//   beat number; a count-based model (beats since the start-of-frame, frames
//   = beats / FRAME_BEATS, address = beats mod DEPTH) predicts every status
//   output and the readback, and a negedge process compares each cycle.
//   Literal expectations pin the model at the end of each scenario.
// -----------------------------------------------------------------------------
module tb_parallel_axis_frame_capture;
  import parallel_axis_frame_capture_pkg::*;

  localparam int SPC   = 2;
  localparam int FFT   = 64;
  localparam int FR    = 4;
  localparam int TU    = 16;
  localparam int FB    = FFT / SPC;
  localparam int DEPTH = FR * FB;
  localparam int AW    = $clog2(DEPTH);
  localparam int OW    = $clog2(FR);
  localparam int DW    = SPC * $bits(cx_t);
  localparam int W     = DW + TU;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, arm, ring, stop, rd_en;
  logic [AW-1:0]        rd_addr;
  logic [W-1:0]         rd_data;
  logic                 rd_valid;
  frame_capture_state_t state;
  logic [31:0]          frames_captured;
  logic [OW-1:0]        oldest_frame;
  logic                 full, wrapped, frame_err;

  parallel_axis_frame_capture_if #(.dtype(cx_t), .SAMP_PER_CLK(SPC), .TUSER(TU)) s_if ();

  parallel_axis_frame_capture #(
    .SAMP_PER_CLK (SPC),
    .FFT_LEN      (FFT),
    .FRAMES       (FR),
    .TUSER        (TU),
    .dtype        (cx_t)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis          (s_if),
    .arm             (arm),
    .ring            (ring),
    .stop            (stop),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .state           (state),
    .frames_captured (frames_captured),
    .oldest_frame    (oldest_frame),
    .full            (full),
    .wrapped         (wrapped),
    .frame_err       (frame_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] mem_m [DEPTH];
  int           m_state, m_n, m_frames, m_oldest;
  bit           m_ring, m_stop_pend, m_sof, m_full, m_wrapped, m_err, m_rd_valid;
  logic [W-1:0] m_rd_data;
  bit           chk_en = 1'b0;

  // Applies the inputs present at this rising edge to the model.
  task automatic model_tick();
    int ps;
    bit cap;
    ps = m_state;
    if (rst) begin
      m_state = 0; m_n = 0; m_frames = 0; m_oldest = 0;
      m_ring = 0; m_stop_pend = 0; m_sof = 1;
      m_full = 0; m_wrapped = 0; m_err = 0;
      m_rd_valid = 0; m_rd_data = '0;
      return;
    end
    m_rd_valid = rd_en;
    if (rd_en) m_rd_data = mem_m[rd_addr];
    cap = s_if.tvalid && (ps == 2 || (ps == 1 && m_sof));
    if (ps == 2 && m_ring && stop) m_stop_pend = 1;
    if (cap) begin
      mem_m[m_n % DEPTH] = {s_if.tuser, s_if.tdata};
      if (s_if.tlast != ((m_n % FB) == FB - 1)) m_err = 1;
      m_n++;
      m_state = 2;
      if (m_n % FB == 0) begin
        m_frames = m_n / FB;
        if (m_ring && (m_n % DEPTH == 0)) m_wrapped = 1;
        if (m_ring && m_wrapped) m_oldest = m_frames % FR;
        if ((!m_ring && m_n == DEPTH) || (m_ring && m_stop_pend)) begin
          m_state = 3;
          m_full  = 1;
        end
      end
    end
    if ((ps == 0 || ps == 3) && arm) begin
      m_state = 1; m_n = 0; m_frames = 0; m_oldest = 0;
      m_full = 0; m_wrapped = 0; m_err = 0;
      m_ring = ring; m_stop_pend = 0;
    end
    if (s_if.tvalid) m_sof = s_if.tlast;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("state",           state,           m_state);
      check("frames_captured", frames_captured, m_frames);
      check("oldest_frame",    oldest_frame,    m_oldest);
      check("full",            full,            m_full);
      check("wrapped",         wrapped,         m_wrapped);
      check("frame_err",       frame_err,       m_err);
      check("rd_valid",        rd_valid,        m_rd_valid);
      check("rd_data",         rd_data,         m_rd_data);
      check("tready",          s_if.tready,     1'b1);
    end
  end

  // ---------------- stimulus ----------------
  int            pos     = 0;   // global stream beat number, also the tuser value
  int            arm_at  = -1;
  int            stop_at = -1;
  int            rst_at  = -1;
  int            rd_at   = -1;
  int            inj_at  = -1;  // beat that gets a spurious or dropped tlast
  int            rd_lit  = 0;
  logic [AW-1:0] rd_at_addr = '0;

  task automatic drive_beat(input bit v);
    logic [DW-1:0] d;
    for (int i = 0; i < SPC; i++) d[i*32 +: 32] = {16'(pos * 4 + i), 16'(pos ^ 'h5a5a)};
    s_if.tvalid = v;
    s_if.tdata  = d;
    s_if.tuser  = 16'(pos);
    s_if.tlast  = v && ((((pos % FB) == FB - 1)) != (pos == inj_at));
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ctl_cycle(input bit a, input bit r, input bit s);
    drive_beat(1'b0);
    arm = a; ring = r; stop = s; rd_en = 1'b0;
    step();
    arm = 1'b0; stop = 1'b0;
  endtask

  task automatic read_cycle(input int addr, input int lit);
    drive_beat(1'b0);
    rd_en = 1'b1; rd_addr = AW'(addr);
    step();
    rd_en = 1'b0;
    check($sformatf("readback[%0d]", addr), rd_data[W-1 -: TU], 16'(lit));
  endtask

  task automatic send(input int n);
    for (int k = 0; k < n; k++) begin
      drive_beat(1'b1);
      arm     = (pos == arm_at);
      stop    = (pos == stop_at);
      rst     = (pos == rst_at);
      rd_en   = (pos == rd_at);
      rd_addr = rd_at_addr;
      step();
      if (pos == rst_at) begin
        check("after_rst_state",    state,           IDLE);
        check("after_rst_frames",   frames_captured, 32'd0);
        check("after_rst_rd_data",  rd_data,         '0);
      end
      if (pos == rd_at) check("same_addr_read_first", rd_data[W-1 -: TU], 16'(rd_lit));
      pos++;
    end
    drive_beat(1'b0);
    arm = 1'b0; stop = 1'b0; rst = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; ring = 1'b0; stop = 1'b0; rd_en = 1'b0; rd_addr = '0;
    drive_beat(1'b0);
    step();
    chk_en = 1'b1;
    check("tready_in_reset", s_if.tready, 1'b1);
    step();
    rst = 1'b0;
    check("reset_state",     state,           IDLE);
    check("reset_frames",    frames_captured, 32'd0);
    check("reset_rd_data",   rd_data,         '0);
    check("reset_full",      full,            1'b0);

    // One-shot: 128 aligned beats fill the buffer.
    ctl_cycle(1'b1, 1'b0, 1'b0);
    check("armed_wait_sof", state, WAIT_SOF);
    send(DEPTH);
    ctl_cycle(1'b0, 1'b0, 1'b0);
    check("oneshot_done",   state,           DONE);
    check("oneshot_full",   full,            1'b1);
    check("oneshot_frames", frames_captured, 32'd4);
    read_cycle(0, 0);
    read_cycle(5, 5);
    read_cycle(127, 127);

    // Arm at beat 10 of a frame: the rest of that frame is discarded.
    arm_at = pos + 10;
    send(FB + DEPTH);
    arm_at = -1;
    check("midarm_done", state, DONE);
    read_cycle(0, 160);
    read_cycle(127, 287);

    // Spurious tlast at beat 20 of frame 2.
    ctl_cycle(1'b1, 1'b0, 1'b0);
    inj_at = pos + 2 * FB + 20;
    send(DEPTH);
    inj_at = -1;
    check("inj_frame_err", frame_err,       1'b1);
    check("inj_frames",    frames_captured, 32'd4);
    check("inj_done",      state,           DONE);
    read_cycle(84, 372);
    read_cycle(127, 415);

    // Ring: stop during frame 7 ends capture at its last beat.
    ctl_cycle(1'b1, 1'b1, 1'b0);
    stop_at = pos + 6 * FB + 10;
    send(7 * FB + 4);
    stop_at = -1;
    check("ring_done",    state,           DONE);
    check("ring_frames",  frames_captured, 32'd7);
    check("ring_wrapped", wrapped,         1'b1);
    check("ring_oldest",  oldest_frame,    2'd3);
    read_cycle(0, 544);
    read_cycle(3 * FB, 512);
    read_cycle(2 * FB + 5, 613);

    // arm and stop together in DONE: arm wins; then reset at capture beat 50.
    ctl_cycle(1'b1, 1'b0, 1'b1);
    check("arm_beats_stop", state, WAIT_SOF);
    rst_at = pos + 28 + 50;
    send(87);
    rst_at = -1;
    ctl_cycle(1'b1, 1'b0, 1'b0);
    send(FB + DEPTH);
    check("rearm_done",   state,           DONE);
    check("rearm_frames", frames_captured, 32'd4);
    read_cycle(0, 736);
    read_cycle(127, 863);

    // Ring capture with a read of address 0 in the cycle it is overwritten.
    ctl_cycle(1'b1, 1'b1, 1'b0);
    rd_at = pos + 5; rd_at_addr = '0; rd_lit = 736;
    send(20);
    rd_at = -1;
    check("collide_capturing", state, CAPTURE);
    read_cycle(0, 896);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/parallel_axis_frame_capture.md
# parallel_axis_frame_capture

Parametrised successor to the parallel AXIS capture VIP at the OSPFB output: stores whole, frame-aligned output frames of `SAMP_PER_CLK` parallel samples per beat into an on-chip buffer. Supports armed one-shot and continuous ring capture, graceful stop, frame-framing error detection and a random-access readback port. Sits on the DSP clock domain after the OSPFB, feeding bench checkers or a register/DMA readout path.

## Interface
- `SAMP_PER_CLK`, 2, samples per AXIS beat
- `FFT_LEN`, 64, samples per frame; must be divisible by `SAMP_PER_CLK`
- `FRAMES`, 4, frames held in the buffer; ≥1
- `TUSER`, 16, tuser width, stored alongside data
- `dtype`, `cx_t`, sample type
- Derived: `FRAME_BEATS = FFT_LEN/SAMP_PER_CLK`, `DEPTH = FRAMES*FRAME_BEATS`, `AW = $clog2(DEPTH)`, `W = SAMP_PER_CLK*$bits(dtype)+TUSER`
- `clk`  in  1  sole clock (DSP domain)
- `rst`  in  1  synchronous, active-high reset
- `s_axis`  slv  `alpaca_data_pkt_axis` (`dtype`, `SAMP_PER_CLK`, `TUSER`)  captured stream; tready held 1
- `arm`  in  1  start request; honoured in IDLE/DONE only
- `ring`  in  1  mode sampled on accepted arm: 0 one-shot, 1 ring
- `stop`  in  1  end ring capture at next frame end; honoured in CAPTURE with ring=1 only
- `rd_en`  in  1  read strobe
- `rd_addr`  in  AW  beat address
- `rd_data`  out  W  {tuser, data} at rd_addr
- `rd_valid`  out  1  rd_data valid
- `state`  out  2  `frame_capture_state_t`
- `frames_captured`  out  32  complete frames written since arm
- `oldest_frame`  out  $clog2(FRAMES) (min 1)  index of oldest complete frame in buffer
- `full`  out  1  buffer complete (DONE)
- `wrapped`  out  1  sticky: ring overwrote data
- `frame_err`  out  1  sticky: tlast misplaced or missing

## Operation
- States IDLE(0), WAIT_SOF(1), CAPTURE(2), DONE(3).
- `sof` flag: set by rst and on every tlast beat; cleared on any other valid beat. Tracked in all states.
- IDLE/DONE + arm → WAIT_SOF; clears frames_captured, wr_addr, beat counter, full, wrapped, frame_err, oldest_frame; latches ring.
- WAIT_SOF: valid beat with sof=1 → written at address 0, → CAPTURE. Beats with sof=0 discarded.
- CAPTURE: every valid beat written at wr_addr, wr_addr++. Beat counter 0..FRAME_BEATS-1.
- Frame end = beat FRAME_BEATS-1. tlast present elsewhere, or absent there → frame_err=1; the counter alone defines frame boundaries.
- Frame end: frames_captured++. If wr_addr = DEPTH-1: one-shot → DONE; ring → wr_addr=0, wrapped=1. In ring after wrap, oldest_frame = next frame index to be overwritten (mod FRAMES); else 0.
- stop latches a pending flag; at next frame end → DONE. stop arriving on a frame-end beat ends capture on that beat.
- arm outside IDLE/DONE and stop outside CAPTURE/ring are ignored; simultaneous arm+stop in DONE: arm wins.
- Readback legal in any state; same-address read/write in one cycle returns old data (read-first).
- rst in any state → IDLE; buffer contents undefined, all outputs to reset values.

## Timing
- Reset values: state=IDLE, rd_valid=0, rd_data=0, frames_captured=0, oldest_frame=0, full=0, wrapped=0, frame_err=0; tready=1 even in reset.
- Write occurs the same cycle the beat is accepted; no backpressure, no beat lost while in CAPTURE.
- state, full, frames_captured, wrapped, frame_err update the cycle after the causing beat.
- Read latency 1: rd_en at cycle n → rd_data/rd_valid at n+1; rd_valid=0 otherwise, rd_data holds.
- Back-to-back re-arm: arm in first DONE cycle → WAIT_SOF next cycle; next captured beat needs sof=1.

## Structure
- `frame_capture_state_t` (2-bit enum) in `alpaca_dtypes_pkg`.
- Sub-module `sdp_ram #(WIDTH, DEPTH)`: simple dual-port, one write/one read port, read-first, 1-cycle registered read. Control FSM and counters in top.

## Test plan
- One-shot, FRAMES=4, FFT_LEN=64, SPC=2: arm, ramp stream with tlast every 32 beats → DONE after 128 beats; full=1, frames_captured=4; readback addr k = beat k.
- Arm mid-frame (beat 10 of 32) → beats 10..31 discarded; rd_addr 0 = next frame's beat 0.
- Ring: run 6 frames, stop during frame 7 → DONE at end of frame 7; frames_captured=7, wrapped=1, oldest_frame=3.
- tlast injected at beat 20 of frame 2 → frame_err=1, capture continues, still 128 beats stored.
- rst asserted at beat 50 of CAPTURE → next cycle state=IDLE, all outputs at reset values; re-arm captures cleanly.
- Read and write same address same cycle → rd_data returns prior contents one cycle later.
